rxuart: RTL and testbench

RXUART -- requirements
Module: rxuart

---
 rtl/rxuart.sv | 177 +++++++++++++++++
 tb/tb_rxuart.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rxuart.sv
// rxuart: asynchronous serial receiver, 8N1 framing by default.
// Optional feature: define RXUART_PARITY_EN for 8E1 framing with o_parity_err.
// The line is resynchronised, the start bit is validated at mid-bit, and every
// following bit is sampled one bit period later.
module rxuart #(
  parameter int unsigned CLOCK_FREQUENCY = 16_000_000,
  parameter int unsigned BAUD_RATE       = 115_200
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_busy,
`ifdef RXUART_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_frame_err
);

  localparam int unsigned BIT_TICKS  = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned HALF_TICKS = BIT_TICKS / 2;
  localparam logic [15:0] BIT_RELOAD  = 16'(BIT_TICKS - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(HALF_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef RXUART_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t      state, state_n;
  logic        rx_meta, rx_sync;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  data_n;
  logic        valid_n, ferr_n;
`ifdef RXUART_PARITY_EN
  logic        par, par_n;
  logic        perr_n;
`endif

  // Two-flop synchronizer on the asynchronous serial line (idles high).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // State register for the frame FSM, datapath and registered strobes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      idx         <= '0;
      shift       <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef RXUART_PARITY_EN
      par          <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shift       <= shift_n;
      o_data      <= data_n;
      o_valid     <= valid_n;
      o_frame_err <= ferr_n;
`ifdef RXUART_PARITY_EN
      par          <= par_n;
      o_parity_err <= perr_n;
`endif
    end
  end

  // Next-state and datapath logic; every sample is taken when cnt reaches 0.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = o_data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef RXUART_PARITY_EN
    par_n   = par;
    perr_n  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!rx_sync) begin
          cnt_n   = HALF_RELOAD;
          state_n = S_START;
        end
      end
      S_START: begin
        if (cnt == '0) begin
          if (!rx_sync) begin
            idx_n   = '0;
            cnt_n   = BIT_RELOAD;
            state_n = S_DATA;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          shift_n = {rx_sync, shift[7:1]};
          cnt_n   = BIT_RELOAD;
          if (idx == 3'd7) begin
`ifdef RXUART_PARITY_EN
            state_n = S_PARITY;
`else
            state_n = S_STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`ifdef RXUART_PARITY_EN
      S_PARITY: begin
        if (cnt == '0) begin
          par_n   = rx_sync;
          cnt_n   = BIT_RELOAD;
          state_n = S_STOP;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt == '0) begin
          if (rx_sync) begin
            data_n  = shift;
            valid_n = 1'b1;
`ifdef RXUART_PARITY_EN
            perr_n  = ^{shift, par};
`endif
            // Leaving at mid-stop-bit lets the next start edge be caught at once.
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_BREAK: begin
        if (rx_sync) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_rxuart.sv
// tb_rxuart: directed self-checking bench for rxuart at default parameters.
module tb_rxuart;

  localparam int unsigned B = 16_000_000 / 115_200;  // 138
  localparam int unsigned H = B / 2;                 // 69
`ifdef RXUART_PARITY_EN
  localparam int unsigned LAT = 2 + H + 10 * B;
`else
  localparam int unsigned LAT = 2 + H + 9 * B;
`endif

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_uart_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_frame_err;
`ifdef RXUART_PARITY_EN
  logic       o_parity_err;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned cyc = 0;
  int unsigned n_valid = 0;
  int unsigned n_ferr = 0;
  int unsigned n_perr = 0;
  int unsigned n_overlap = 0;
  int unsigned valid_cyc = 0;
  logic [7:0] rxq[$];

  rxuart #(.CLOCK_FREQUENCY(16_000_000), .BAUD_RATE(115_200)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_uart_rx   (i_uart_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_busy      (o_busy),
`ifdef RXUART_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_frame_err (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  // Strobe monitor: samples 1 time unit after each rising edge.
  always begin
    @(posedge i_clk);
    cyc++;
    #1;
    if (o_valid) begin
      n_valid++;
      valid_cyc = cyc;
      rxq.push_back(o_data);
    end
    if (o_frame_err) n_ferr++;
    if (o_valid && o_frame_err) n_overlap++;
`ifdef RXUART_PARITY_EN
    if (o_parity_err) n_perr++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic bit_out(input logic v);
    i_uart_rx = v;
    wait_cycles(B);
  endtask

  // One frame, LSB first; par_flip inverts the (even) parity bit when present.
  task automatic send(input logic [7:0] d, input logic stop, input logic par_flip);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef RXUART_PARITY_EN
    bit_out((^d) ^ par_flip);
`endif
    bit_out(stop);
  endtask

  int unsigned t0, lat, nv;

  initial begin
    i_reset   = 1'b1;
    i_uart_rx = 1'b1;
    wait_cycles(3);
    check("rst_data",  {24'd0, o_data}, 32'h00);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_busy",  {31'd0, o_busy}, 32'd0);
    check("rst_ferr",  {31'd0, o_frame_err}, 32'd0);
    i_reset = 1'b0;
    wait_cycles(10);

    // Single frame 0xA5 with latency measurement.
    t0 = cyc;
    send(8'hA5, 1'b1, 1'b0);
    wait_cycles(20);
    lat = valid_cyc - t0;
    check("a5_count", n_valid, 32'd1);
    check("a5_data",  {24'd0, o_data}, 32'hA5);
    check("a5_ferr",  n_ferr, 32'd0);
    check("a5_latency_window", {31'd0, (lat + 1 >= LAT) && (lat <= LAT + 1)}, 32'd1);

    // Back-to-back frames with no idle gap.
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    wait_cycles(20);
    check("b2b_count", n_valid, 32'd4);
    check("b2b_q1", {24'd0, rxq[1]}, 32'h00);
    check("b2b_q2", {24'd0, rxq[2]}, 32'hFF);
    check("b2b_q3", {24'd0, rxq[3]}, 32'h55);
    check("b2b_busy", {31'd0, o_busy}, 32'd0);

    // 40-cycle low glitch: false start, no strobe.
    i_uart_rx = 1'b0;
    wait_cycles(40);
    i_uart_rx = 1'b1;
    check("glitch_busy_hi", {31'd0, o_busy}, 32'd1);
    wait_cycles(H + 3);
    check("glitch_busy_lo", {31'd0, o_busy}, 32'd0);
    check("glitch_count", n_valid, 32'd4);
    check("glitch_ferr", n_ferr, 32'd0);

    // Frame error: stop bit low, line held low, then released.
    send(8'h3C, 1'b0, 1'b0);
    i_uart_rx = 1'b0;
    wait_cycles(500);
    check("ferr_count", n_ferr, 32'd1);
    check("ferr_valid_count", n_valid, 32'd4);
    check("ferr_data_kept", {24'd0, o_data}, 32'h55);
    check("ferr_busy_break", {31'd0, o_busy}, 32'd1);
    i_uart_rx = 1'b1;
    wait_cycles(5);
    check("ferr_busy_released", {31'd0, o_busy}, 32'd0);
    wait_cycles(50);
    send(8'h81, 1'b1, 1'b0);
    wait_cycles(20);
    check("after_ferr_count", n_valid, 32'd5);
    check("after_ferr_data", {24'd0, o_data}, 32'h81);

    // Reset during bit 4 of 0x96.
    bit_out(1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    bit_out(1'b0);
    i_uart_rx = 1'b1;
    wait_cycles(H);
    i_reset = 1'b1;
    wait_cycles(2);
    check("midrst_data",  {24'd0, o_data}, 32'h00);
    check("midrst_valid", {31'd0, o_valid}, 32'd0);
    check("midrst_busy",  {31'd0, o_busy}, 32'd0);
    check("midrst_ferr",  {31'd0, o_frame_err}, 32'd0);
    i_reset = 1'b0;
    wait_cycles(2 * B);
    check("midrst_no_strobe", n_valid, 32'd5);
    send(8'h42, 1'b1, 1'b0);
    wait_cycles(20);
    check("after_rst_count", n_valid, 32'd6);
    check("after_rst_data", {24'd0, o_data}, 32'h42);

`ifdef RXUART_PARITY_EN
    nv = n_valid;
    send(8'h07, 1'b1, 1'b0);
    wait_cycles(20);
    check("par_ok_valid", n_valid, nv + 1);
    check("par_ok_perr", n_perr, 32'd0);
    send(8'h07, 1'b1, 1'b1);
    wait_cycles(20);
    check("par_bad_valid", n_valid, nv + 2);
    check("par_bad_perr", n_perr, 32'd1);
    check("par_bad_data", {24'd0, o_data}, 32'h07);
`endif

    check("strobe_overlap", n_overlap, 32'd0);
    check("total_frame_errs", n_ferr, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
